// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for alu_seq_exec.
// Master drives the operation and out_ready; slave returns in_ready, out_valid and the result.
interface alu_seq_exec_if #(
  parameter int DATA_WIDTH = 32
);
  // Valid/ready semantics, both channels: a transfer happens on a rising clk edge
  // where valid && ready. The producer holds valid and payload until then.
  // The consumer may raise or drop ready freely.
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult
  );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle logic/arith/compare ops.
// Shifts run one bit per cycle in a SHIFT state; the result is held in DONE until it is taken.
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_seq_exec_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] result;
  logic [SW-1:0]         cnt;
  logic [3:0]            op_q;

  logic [DATA_WIDTH-1:0] alu_y;
  logic [DATA_WIDTH-1:0] shift1;
  logic [SW-1:0]         shamt;
  logic                  is_shift;
  logic                  lt;

  assign shamt    = bus.SrcB[SW-1:0];
  assign is_shift = (bus.Operation == OP_SRL) || (bus.Operation == OP_SLL) ||
                    (bus.Operation == OP_SRA);
  assign lt       = $signed(bus.SrcA) < $signed(bus.SrcB);

  always_comb begin
    alu_y = '0;
    case (bus.Operation)
      4'b0000: alu_y = bus.SrcA & bus.SrcB;
      4'b0001: alu_y = bus.SrcA | bus.SrcB;
      4'b0010: alu_y = bus.SrcA + bus.SrcB;
      4'b0011: alu_y = bus.SrcA - bus.SrcB;
      4'b0100: alu_y = bus.SrcA ^ bus.SrcB;
      4'b0101: alu_y = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'b0110: alu_y = bus.SrcB;
      4'b1000: alu_y = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
      4'b1100: alu_y = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'b1111: alu_y = {{(DATA_WIDTH-1){1'b0}}, ~lt};
      default: alu_y = '0;
    endcase
  end

  // op_q only ever holds a shift opcode while in SHIFT; anything not SLL/SRL is SRA.
  always_comb begin
    shift1 = '0;
    case (op_q)
      OP_SLL:  shift1 = {result[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, result[DATA_WIDTH-1:1]};
      default: shift1 = {result[DATA_WIDTH-1], result[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
      op_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.Operation;
            if (is_shift) begin
              result <= bus.SrcA;
              cnt    <= shamt;
              state  <= (shamt == '0) ? DONE : SHIFT;
            end else begin
              result <= alu_y;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          result <= shift1;
          cnt    <= cnt - SW'(1);
          if (cnt == SW'(1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ALUResult = result;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed bench for alu_seq_exec against a plain-arithmetic reference model.
module tb_alu_seq_exec;
  localparam int W = 32;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  alu_seq_exec_if #(.DATA_WIDTH(W)) bus ();

  alu_seq_exec #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    logic signed [W-1:0] sa;
    sh = int'(b % W);
    sa = a;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:  return b;
      4'd7:  return a >> sh;
      4'd8:  return (a == b) ? 1 : 0;
      4'd9:  return a << sh;
      4'd10: return sa >>> sh;
      4'd12: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd15: return ($signed(a) >= $signed(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'd7 || op == 4'd9 || op == 4'd10) return 1 + int'(b % W);
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that completed the result handshake.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
    int lat;
    int exp_lat;
    logic [W-1:0] exp;
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.out_ready = 1'($urandom_range(0, 1));
    chk("in_ready_idle", W'(bus.in_ready), W'(1));
    exp_q.push_back(ref_alu(op, a, b));
    exp_lat = ref_lat(op, b);
    @(posedge clk); #1;
    lat = 1;
    // Inputs scrambled while the DUT is busy; none of it may matter.
    while (!bus.out_valid && lat < 200) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.Operation = 4'($urandom);
      bus.SrcA      = $urandom;
      bus.SrcB      = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      chk("in_ready_busy", W'(bus.in_ready), W'(0));
      @(posedge clk); #1;
      lat++;
    end
    bus.out_ready = 1'b0;
    chk("out_valid", W'(bus.out_valid), W'(1));
    chk("latency", W'(lat), W'(exp_lat));
    exp = exp_q.pop_front();
    chk($sformatf("result_op%0d", op), bus.ALUResult, exp);
    repeat (hold) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.SrcA     = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", W'(bus.out_valid), W'(1));
      chk("hold_in_ready", W'(bus.in_ready), W'(0));
      chk("hold_result", bus.ALUResult, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_valid", W'(bus.out_valid), W'(0));
    chk("post_in_ready", W'(bus.in_ready), W'(1));
    chk("idle_keeps_result", bus.ALUResult, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.Operation = '0; bus.SrcA = '0; bus.SrcB = '0;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_result", bus.ALUResult, W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // directed vectors
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    do_op(4'b1010, 32'h8000_0000, 32'h4, 2);
    do_op(4'b1001, 32'h1, 32'h25, 1);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'h0, 0);
    do_op(4'b1111, 32'hFFFF_FFFF, 32'h0, 0);
    do_op(4'b1000, 32'h1234, 32'h1234, 0);
    do_op(4'b1101, 32'h1234, 32'h1234, 0);
    do_op(4'b0011, 32'h5, 32'h7, 10);
    do_op(4'b1001, 32'h1, 32'h3, 0);
    do_op(4'b0111, 32'hDEAD_BEEF, 32'h40, 1);
    do_op(4'b1010, 32'h8000_0001, 32'h1F, 0);

    // randomized
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 8)) : $urandom;
      do_op(op, a, b, $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a long shift
    bus.in_valid = 1'b1; bus.Operation = 4'b0111;
    bus.SrcA = $urandom | 32'h8000_0000; bus.SrcB = 32'd31;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midshift_out_valid", W'(bus.out_valid), W'(0));
    chk("midshift_result", bus.ALUResult, W'(0));
    chk("midshift_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abandoned_no_result", W'(seen), W'(0));

    // acceptance on the first edge after reset release
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.Operation = 4'b0100;
    bus.SrcA = 32'hA5A5_0F0F; bus.SrcB = 32'h0FF0_FFFF;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("first_edge_valid", W'(bus.out_valid), W'(1));
    chk("first_edge_result", bus.ALUResult, ref_alu(4'b0100, 32'hA5A5_0F0F, 32'h0FF0_FFFF));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("first_edge_done", W'(bus.out_valid), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values are powers of two, 8 or more; SW = log2(DATA_WIDTH).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port Operation  input  4  ALU operation code from the ALU controller.
REQ-007 SHALL have port SrcA  input  DATA_WIDTH  first operand.
REQ-008 SHALL have port SrcB  input  DATA_WIDTH  second operand; bits [SW-1:0] are the shift amount for shifts.
REQ-009 SHALL have port out_valid  output  1  ALUResult holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port ALUResult  output  DATA_WIDTH  registered result.

Function
REQ-012 SHALL decode Operation: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLT signed, 0110 pass SrcB, 0111 SRL, 1000 EQ, 1001 SLL, 1010 SRA, 1100 LT signed, 1111 GE signed; 1011/1101/1110 yield result 0.
REQ-013 SHALL produce compare results (SLT, EQ, LT, GE) as 1 or 0 zero-extended to DATA_WIDTH.
REQ-014 SHALL wrap ADD/SUB modulo 2^DATA_WIDTH, no carry or overflow output.
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept a request when in_valid && in_ready, capturing Operation, SrcA, SrcB in that cycle.
REQ-018 SHALL, for non-shift ops, register the result and enter DONE on the accept edge (out_valid high the next cycle, latency 1).
REQ-019 SHALL, for SLL/SRL/SRA with shamt = 0, load SrcA unchanged and enter DONE directly (latency 1).
REQ-020 SHALL, for shifts with shamt > 0, load SrcA into the result register, load a down-counter with shamt, and enter SHIFT.
REQ-021 SHALL, in SHIFT, shift the result register by exactly one bit per cycle (SLL zero-fill LSB, SRL zero-fill MSB, SRA replicate MSB) and decrement the counter.
REQ-022 SHALL leave SHIFT for DONE on the cycle the counter steps 1 -> 0; out_valid rises 1 + shamt cycles after accept.
REQ-023 SHALL hold ALUResult and out_valid stable in DONE while out_ready = 0, indefinitely.
REQ-024 SHALL return to IDLE on out_valid && out_ready; no new request is accepted in that same cycle (one bubble between operations).
REQ-025 SHALL ignore in_valid and all operand inputs outside IDLE; input changes during SHIFT/DONE SHALL NOT affect the result.
REQ-026 SHALL ignore out_ready outside DONE.
REQ-027 SHALL keep ALUResult unchanged in IDLE (last delivered value visible).

Reset
REQ-028 SHALL, on reset assertion, immediately force state IDLE, ALUResult = 0, counter = 0, in_ready = 1, out_valid = 0, regardless of clock.
REQ-029 SHALL abandon any operation in SHIFT or DONE on reset without emitting a result.
REQ-030 SHALL accept a new request on the first rising edge after reset deassertion.

Verification
REQ-031 ADD: SrcA=0x7FFFFFFF, SrcB=1, Op=0010, out_ready=1 -> out_valid one cycle later, ALUResult=0x80000000, in_ready back high the cycle after.
REQ-032 SRA: SrcA=0x80000000, SrcB=4, Op=1010 -> out_valid exactly 5 cycles after accept, ALUResult=0xF8000000; SLL SrcB=0x25 (shamt 5) on 0x1 -> 0x20 after 6 cycles.
REQ-033 Compares: Op=1100 SrcA=0xFFFFFFFF, SrcB=0 -> 1; Op=1111 same operands -> 0; Op=1000 SrcA=SrcB=0x1234 -> 1; Op=1101 -> 0.
REQ-034 Backpressure: Op=0011 SrcA=5 SrcB=7, out_ready=0 for 10 cycles -> ALUResult=0xFFFFFFFE, out_valid held 10 cycles, in_valid pulses meanwhile ignored, in_ready low throughout.
REQ-035 Reset mid-shift: SRL shamt=31 accepted, reset asserted asynchronously at cycle 10 -> out_valid=0, ALUResult=0, in_ready=1 before next clock edge; no result ever emitted.
REQ-036 Operand hold: during SHIFT of SLL shamt=3 on 0x1, change SrcA/SrcB/Operation every cycle -> result still 0x8 at cycle 4.
